writeback_stage: RTL and testbench

- Final pipeline stage, directly upstream of the register file.
- Selects the value to retire: ALU result, link address (PC+4), or data-bus load data.
- Loads are aligned and sign/zero extended, and waits on the data-bus read handshake are absorbed.
- Drives the register file write port (write_reg, write_data, cs_reg_write) as registered one-cycle pulses, and flags faulting loads.

---
 rtl/writeback_stage.sv | 155 +++++++++++++++
 tb/tb_writeback_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU/link/load results to the register file, 1-cycle registered write pulse
// (loads: 1 cycle after bus_ready). in_ready drops while a load waits on the data bus or times out.
module writeback_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_src,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus_4,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ready,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        cs_reg_write,
  output logic        load_fault
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } load_meta_t;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  load_meta_t      pend, pend_n;
  logic [4:0]      write_reg_n;
  logic [31:0]     write_data_n;
  logic            cs_reg_write_n;
  logic            load_fault_n;
  logic            load_ok;
  logic [31:0]     load_value;

  function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  align_load = {{24{b[7]}}, b};
      3'b001:  align_load = {{16{h[15]}}, h};
      3'b100:  align_load = {24'd0, b};
      3'b101:  align_load = {16'd0, h};
      default: align_load = w;
    endcase
  endfunction

  // Legal load type with natural alignment for its access size.
  always_comb begin
    load_ok = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~in_addr_lo[0];
      3'b010:         load_ok = (in_addr_lo == 2'b00);
      default:        load_ok = 1'b0;
    endcase
  end

  assign load_value = align_load(pend.funct3, pend.addr_lo, bus_read_data);
  assign in_ready   = (state == IDLE);

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    pend_n         = pend;
    write_reg_n    = write_reg;
    write_data_n   = write_data;
    cs_reg_write_n = 1'b0;
    load_fault_n   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (in_src)
            SRC_ALU, SRC_LINK: begin
              write_reg_n    = in_rd;
              write_data_n   = (in_src == SRC_ALU) ? in_alu_result : in_pc_plus_4;
              cs_reg_write_n = (in_rd != 5'd0);
            end
            SRC_LOAD: begin
              if (load_ok) begin
                state_n = LOAD_WAIT;
                cnt_n   = '0;
                pend_n  = '{rd: in_rd, funct3: in_funct3, addr_lo: in_addr_lo};
              end else begin
                load_fault_n = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      LOAD_WAIT: begin
        // Data arriving on the final wait cycle still wins over the timeout.
        if (bus_ready) begin
          state_n        = IDLE;
          write_reg_n    = pend.rd;
          write_data_n   = load_value;
          cs_reg_write_n = (pend.rd != 5'd0);
        end else if (cnt == CNT_LAST) begin
          state_n      = IDLE;
          load_fault_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pend         <= '0;
      write_reg    <= '0;
      write_data   <= '0;
      cs_reg_write <= 1'b0;
      load_fault   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pend         <= pend_n;
      write_reg    <= write_reg_n;
      write_data   <= write_data_n;
      cs_reg_write <= cs_reg_write_n;
      load_fault   <= load_fault_n;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage with a transaction-level reference model.
module tb_writeback_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_src;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus_4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] bus_read_data;
  logic        bus_ready;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        cs_reg_write;
  logic        load_fault;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  writeback_stage #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_src(in_src), .in_alu_result(in_alu_result),
    .in_pc_plus_4(in_pc_plus_4), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .bus_read_data(bus_read_data), .bus_ready(bus_ready),
    .write_reg(write_reg), .write_data(write_data),
    .cs_reg_write(cs_reg_write), .load_fault(load_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_we"}, {31'd0, cs_reg_write}, 32'd0);
    chk({tag, "_flt"}, {31'd0, load_fault}, 32'd0);
  endtask

  // Load result from the ISA rules: shift the word down, then mask or sign-adjust numerically.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] s;
    int v;
    s = w >> (int'(lo) * 8);
    case (f3)
      3'b000: begin v = int'(s & 32'hFF); if (v > 127) v = v - 256; return v; end
      3'b001: begin v = int'(s & 32'hFFFF); if (v > 32767) v = v - 65536; return v; end
      3'b100: return s & 32'hFF;
      3'b101: return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_load_ok(input logic [2:0] f3, input logic [1:0] lo);
    int size;
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    size = 1 << int'(f3 & 3'b011);
    return (int'(lo) % size) == 0;
  endfunction

  task automatic scramble_inputs();
    in_rd         = 5'($urandom);
    in_src        = 2'($urandom);
    in_alu_result = $urandom;
    in_pc_plus_4  = $urandom;
    in_funct3     = 3'($urandom);
    in_addr_lo    = 2'($urandom);
  endtask

  task automatic idle_cycle();
    in_valid  = 1'b0;
    bus_ready = 1'($urandom);
    scramble_inputs();
    step();
    chk_quiet("idle");
    chk("idle_rdy", {31'd0, in_ready}, 32'd1);
  endtask

  // wait_n: non-ready LOAD_WAIT cycles before bus_ready; negative or >= T means never.
  task automatic do_txn(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] lo,
                        input int wait_n, input logic [31:0] word);
    chk("acc_rdy", {31'd0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    in_src        = src;
    in_rd         = rd;
    in_alu_result = alu;
    in_pc_plus_4  = pc;
    in_funct3     = f3;
    in_addr_lo    = lo;
    bus_ready     = 1'($urandom);
    bus_read_data = $urandom;
    step();
    in_valid  = 1'b0;
    bus_ready = 1'b0;
    scramble_inputs();
    if (src == 2'b00 || src == 2'b10) begin
      chk("rr_we", {31'd0, cs_reg_write}, {31'd0, rd != 5'd0});
      chk("rr_reg", {27'd0, write_reg}, {27'd0, rd});
      chk("rr_data", write_data, (src == 2'b00) ? alu : pc);
      chk("rr_flt", {31'd0, load_fault}, 32'd0);
      chk("rr_rdy", {31'd0, in_ready}, 32'd1);
    end else if (src == 2'b11) begin
      chk_quiet("none");
      chk("none_rdy", {31'd0, in_ready}, 32'd1);
    end else if (!ref_load_ok(f3, lo)) begin
      chk("bad_flt", {31'd0, load_fault}, 32'd1);
      chk("bad_we", {31'd0, cs_reg_write}, 32'd0);
      chk("bad_rdy", {31'd0, in_ready}, 32'd1);
    end else begin
      for (int k = 0; k < T; k++) begin
        chk("wait_rdy", {31'd0, in_ready}, 32'd0);
        chk_quiet("wait");
        if (k == wait_n) begin
          bus_ready     = 1'b1;
          bus_read_data = word;
        end else begin
          bus_ready     = 1'b0;
          bus_read_data = $urandom;
        end
        step();
        if (k == wait_n) begin
          chk("ld_we", {31'd0, cs_reg_write}, {31'd0, rd != 5'd0});
          if (rd != 5'd0) begin
            chk("ld_reg", {27'd0, write_reg}, {27'd0, rd});
            chk("ld_data", write_data, ref_load(f3, lo, word));
          end
          chk("ld_flt", {31'd0, load_fault}, 32'd0);
          chk("ld_rdy", {31'd0, in_ready}, 32'd1);
          break;
        end
        if (k == T - 1) begin
          chk("to_flt", {31'd0, load_fault}, 32'd1);
          chk("to_we", {31'd0, cs_reg_write}, 32'd0);
          chk("to_rdy", {31'd0, in_ready}, 32'd1);
        end
      end
      bus_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    bus_ready     = 1'b0;
    bus_read_data = '0;
    scramble_inputs();
    repeat (3) step();
    reset = 1'b0;
    chk("rst_reg", {27'd0, write_reg}, 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk_quiet("rst");
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    // ALU then back-to-back LINK, then the pulse must drop.
    do_txn(2'b00, 5'd5, 32'hDEADBEEF, 32'h0, 3'b000, 2'd0, 0, 32'h0);
    do_txn(2'b10, 5'd1, 32'h0, 32'h104, 3'b000, 2'd0, 0, 32'h0);
    idle_cycle();
    do_txn(2'b00, 5'd9, 32'h0BADF00D, 32'h0, 3'b000, 2'd0, 0, 32'h0);
    idle_cycle();

    // Byte loads, bus_ready arriving on the final allowed wait cycle.
    do_txn(2'b01, 5'd7, 32'h0, 32'h0, 3'b000, 2'd3, T - 1, 32'h80FF1234);
    do_txn(2'b01, 5'd7, 32'h0, 32'h0, 3'b100, 2'd3, T - 1, 32'h80FF1234);
    do_txn(2'b01, 5'd8, 32'h0, 32'h0, 3'b001, 2'd2, 1, 32'h7FFF0000);
    do_txn(2'b01, 5'd8, 32'h0, 32'h0, 3'b001, 2'd1, 0, 32'h7FFF0000);
    do_txn(2'b01, 5'd8, 32'h0, 32'h0, 3'b011, 2'd0, 0, 32'h7FFF0000);
    do_txn(2'b01, 5'd3, 32'h0, 32'h0, 3'b010, 2'd0, -1, 32'h0);
    do_txn(2'b01, 5'd0, 32'h0, 32'h0, 3'b010, 2'd0, 0, 32'h12345678);
    do_txn(2'b00, 5'd0, 32'h55AA55AA, 32'h0, 3'b000, 2'd0, 0, 32'h0);
    do_txn(2'b11, 5'd4, 32'h1, 32'h2, 3'b000, 2'd0, 0, 32'h0);

    // Reset in the second LOAD_WAIT cycle discards the load.
    chk("rl_acc_rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_src = 2'b01; in_rd = 5'd9; in_funct3 = 3'b010; in_addr_lo = 2'd0;
    step();
    in_valid = 1'b0; bus_ready = 1'b0;
    chk("rl_w0_rdy", {31'd0, in_ready}, 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; bus_ready = 1'b1; bus_read_data = 32'hCAFEF00D;
    chk("rl_reg", {27'd0, write_reg}, 32'd0);
    chk("rl_data", write_data, 32'd0);
    chk_quiet("rl");
    chk("rl_rdy", {31'd0, in_ready}, 32'd1);
    step();
    bus_ready = 1'b0;
    chk_quiet("rl_after");
    chk("rl_after_rdy", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] s;
      logic [2:0] f;
      s = 2'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && f inside {3'b000, 3'b001}) f = f | 3'b100;
      do_txn(s, 5'($urandom), $urandom, $urandom, f, 2'($urandom),
             int'($urandom_range(0, T + 1)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
